// File: rtl/note_sequencer_pkg.sv
// Shared types for the PS/2 note sequencer: note encoding, scan-code constants,
// key-to-note lookup and the frame FSM state encoding.
package note_pkg;

  typedef enum logic [3:0] {
    NOTE_OFF = 4'd0,
    NOTE_A3  = 4'd1,
    NOTE_B3  = 4'd2,
    NOTE_C4  = 4'd3,
    NOTE_D4  = 4'd4,
    NOTE_E4  = 4'd5,
    NOTE_F4  = 4'd6,
    NOTE_G4  = 4'd7,
    NOTE_A4  = 4'd8
  } note_t;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DECODE} state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_KEY_A3 = 8'h1C;
  localparam logic [7:0] SC_KEY_B3 = 8'h1B;
  localparam logic [7:0] SC_KEY_C4 = 8'h23;
  localparam logic [7:0] SC_KEY_D4 = 8'h2B;
  localparam logic [7:0] SC_KEY_E4 = 8'h34;
  localparam logic [7:0] SC_KEY_F4 = 8'h33;
  localparam logic [7:0] SC_KEY_G4 = 8'h3B;
  localparam logic [7:0] SC_KEY_A4 = 8'h42;

  function automatic note_t scan_to_note(input logic [7:0] code);
    case (code)
      SC_KEY_A3: return NOTE_A3;
      SC_KEY_B3: return NOTE_B3;
      SC_KEY_C4: return NOTE_C4;
      SC_KEY_D4: return NOTE_D4;
      SC_KEY_E4: return NOTE_E4;
      SC_KEY_F4: return NOTE_F4;
      SC_KEY_G4: return NOTE_G4;
      SC_KEY_A4: return NOTE_A4;
      default:   return NOTE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Keyboard-side lines and note/frame status outputs of the note sequencer.
interface note_sequencer_if;
  logic       kb_clk;
  logic       kb_data;
  logic [3:0] sel;
  logic       note_on;
  logic [7:0] scan_code;
  logic       frame_valid;
  logic       frame_err;

  modport master (output kb_clk, kb_data,
                  input  sel, note_on, scan_code, frame_valid, frame_err);
  modport slave  (input  kb_clk, kb_data,
                  output sel, note_on, scan_code, frame_valid, frame_err);
endinterface

// File: rtl/note_sequencer_ps2_sync_edge.sv
// Two-flop synchronisers for raw PS/2 clock/data and a falling-edge detector
// on the synchronised clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic kb_clk,
  input  logic kb_data,
  output logic data,
  output logic fall
);

  logic [2:0] clk_sync;
  logic [1:0] data_sync;

  // Cleared to 0 so a line already high at reset release never looks like a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '0;
      data_sync <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value.
      clk_sync  <= {clk_sync[1:0], kb_clk};
      data_sync <= {data_sync[0], kb_data};
    end
  end

  assign fall = !clk_sync[1] && clk_sync[2];
  assign data = data_sync[1];

endmodule

// File: rtl/note_sequencer.sv
// PS/2 frame receiver and hold-until-release note controller.
// Optional auto-release of a held note is enabled by NOTE_AUTO_RELEASE_EN.
module note_sequencer
  import note_pkg::*;
#(
  parameter int BIT_TIMEOUT = 2080
`ifdef NOTE_AUTO_RELEASE_EN
  , parameter int RELEASE_CYC = 1248000
`endif
) (
  input  logic              clk,
  input  logic              reset,
  note_sequencer_if.slave   kb
);

  localparam int TMO_W = $clog2(BIT_TIMEOUT + 1);

  logic             fall;
  logic             data;
  state_t           state, state_d;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       scan_code;
  logic             frame_valid, frame_err;
  logic             fv_d, fe_d;
  note_t            sel, sel_d, mapped;
  logic             note_on;
  logic             brk_pend, ext_pend, brk_d, ext_d;
  logic             frame_ok;

  ps2_sync_edge u_sync (
    .clk     (clk),
    .reset   (reset),
    .kb_clk  (kb.kb_clk),
    .kb_data (kb.kb_data),
    .data    (data),
    .fall    (fall)
  );

  // shreg holds {stop, parity, data[7:0]} once all ten post-start bits are in.
  assign frame_ok = (^shreg[8:0]) && shreg[9];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    state_d = state;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state)
      IDLE:   if (fall && !data) state_d = SHIFT;
      SHIFT: begin
        if (fall) begin
          if (bit_cnt == 4'd9) state_d = CHECK;
        end else if (tmo_cnt == TMO_W'(BIT_TIMEOUT)) begin
          fe_d    = 1'b1;
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (frame_ok) begin
          fv_d    = 1'b1;
          state_d = DECODE;
        end else begin
          fe_d    = 1'b1;
          state_d = IDLE;
        end
      end
      DECODE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef NOTE_AUTO_RELEASE_EN
  logic        is_make;
  logic [20:0] rel_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              rel_cnt <= '0;
    else if (is_make)                       rel_cnt <= 21'(RELEASE_CYC);
    else if (sel != NOTE_OFF && rel_cnt != '0) rel_cnt <= rel_cnt - 21'd1;
  end
`endif

  // Note rules; a decoded make overrides an auto-release in the same cycle.
  always_comb begin
    sel_d  = sel;
    brk_d  = brk_pend;
    ext_d  = ext_pend;
    mapped = scan_to_note(scan_code);
`ifdef NOTE_AUTO_RELEASE_EN
    is_make = 1'b0;
    if (sel != NOTE_OFF && rel_cnt == '0) sel_d = NOTE_OFF;
`endif
    if (state == DECODE) begin
      if (scan_code == SC_EXT) begin
        ext_d = 1'b1;
      end else if (scan_code == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        if (mapped != NOTE_OFF && !ext_pend) begin
          if (!brk_pend) begin
            sel_d = mapped;
`ifdef NOTE_AUTO_RELEASE_EN
            is_make = 1'b1;
`endif
          end else if (mapped == sel) begin
            sel_d = NOTE_OFF;
          end
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      tmo_cnt     <= '0;
      scan_code   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      sel         <= NOTE_OFF;
      note_on     <= 1'b0;
      brk_pend    <= 1'b0;
      ext_pend    <= 1'b0;
    end else begin
      frame_valid <= fv_d;
      frame_err   <= fe_d;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          tmo_cnt <= '0;
        end
        SHIFT: begin
          if (fall) begin
            shreg   <= {data, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        CHECK: if (frame_ok) scan_code <= shreg[7:0];
        default: ;
      endcase
      sel      <= sel_d;
      note_on  <= (sel_d != NOTE_OFF);
      brk_pend <= brk_d;
      ext_pend <= ext_d;
    end
  end

  assign kb.sel         = sel;
  assign kb.note_on     = note_on;
  assign kb.scan_code   = scan_code;
  assign kb.frame_valid = frame_valid;
  assign kb.frame_err   = frame_err;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed keyboard scenarios followed
// by random frames, compared against a table-driven key/prefix model.
module tb_note_sequencer;

  localparam int H = 20;  // clk cycles per kb_clk half period

  logic clk = 1'b0;
  logic reset = 1'b1;
  note_sequencer_if ifc ();

  note_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .kb    (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts pulses and captures sel during and after frame_valid.
  int         fv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  logic       fv_prev = 1'b0;
  logic [3:0] sel_at_fv = '0, sel_after_fv = '0;

  always @(negedge clk) begin
    if (ifc.frame_valid === 1'b1) begin
      fv_cnt    <= fv_cnt + 1;
      sel_at_fv <= ifc.sel;
    end
    if (ifc.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (ifc.frame_valid === 1'b1 && ifc.frame_err === 1'b1) both_cnt <= both_cnt + 1;
    if (fv_prev) sel_after_fv <= ifc.sel;
    fv_prev <= (ifc.frame_valid === 1'b1);
  end

  // Reference model of the keyboard-to-note rules.
  logic [7:0] key_tab [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
  int         m_sel = 0;
  bit         m_brk = 0, m_ext = 0;
  logic [7:0] m_scan = '0;

  function automatic int key_index(input logic [7:0] code);
    for (int i = 0; i < 8; i++) if (key_tab[i] == code) return i + 1;
    return 0;
  endfunction

  task automatic model_apply(input logic [7:0] code);
    int n;
    m_scan = code;
    if (code == 8'hF0)      m_brk = 1;
    else if (code == 8'hE0) m_ext = 1;
    else begin
      n = key_index(code);
      if (n != 0 && !m_ext) begin
        if (!m_brk)          m_sel = n;
        else if (n == m_sel) m_sel = 0;
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic drive_bit(input logic b);
    ifc.kb_data = b;
    repeat (H) @(posedge clk);
    ifc.kb_clk = 1'b0;
    repeat (H) @(posedge clk);
    ifc.kb_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^code) ^ bad_par;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(code[i]);
    drive_bit(par);
    drive_bit(!bad_stop);
    ifc.kb_data = 1'b1;
    repeat (H) @(posedge clk);
  endtask

  // Sends one frame and checks pulses, payload and note state against the model.
  task automatic frame_check(input string tag, input logic [7:0] code,
                             input bit bad_par, input bit bad_stop);
    int fv0, fe0, old_sel;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    old_sel = m_sel;
    send_frame(code, bad_par, bad_stop);
    @(negedge clk);
    if (!bad_par && !bad_stop) begin
      model_apply(code);
      check({tag, ".fv"}, 32'(fv_cnt - fv0), 32'd1);
      check({tag, ".fe"}, 32'(fe_cnt - fe0), 32'd0);
      check({tag, ".sel_at_fv"}, 32'(sel_at_fv), 32'(old_sel));
      check({tag, ".sel_after_fv"}, 32'(sel_after_fv), 32'(m_sel));
    end else begin
      check({tag, ".fv"}, 32'(fv_cnt - fv0), 32'd0);
      check({tag, ".fe"}, 32'(fe_cnt - fe0), 32'd1);
    end
    check({tag, ".scan"}, 32'(ifc.scan_code), 32'(m_scan));
    check({tag, ".sel"}, 32'(ifc.sel), 32'(m_sel));
    check({tag, ".note_on"}, 32'(ifc.note_on), 32'(m_sel != 0));
  endtask

  initial begin
    logic [7:0] code;
    int fe0, fv0, r;
    bit bp, bs;
    ifc.kb_clk  = 1'b1;
    ifc.kb_data = 1'b1;
    repeat (5) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst.sel", 32'(ifc.sel), 32'd0);
    check("rst.note_on", 32'(ifc.note_on), 32'd0);
    check("rst.scan", 32'(ifc.scan_code), 32'd0);
    check("rst.fv", 32'(ifc.frame_valid), 32'd0);
    check("rst.fe", 32'(ifc.frame_err), 32'd0);

    frame_check("make_a", 8'h1C, 0, 0);
    frame_check("brk_other_f0", 8'hF0, 0, 0);
    frame_check("brk_other_1b", 8'h1B, 0, 0);
    frame_check("brk_a_f0", 8'hF0, 0, 0);
    frame_check("brk_a_1c", 8'h1C, 0, 0);
    frame_check("lpw_1c", 8'h1C, 0, 0);
    frame_check("lpw_42", 8'h42, 0, 0);
    frame_check("lpw_f0", 8'hF0, 0, 0);
    frame_check("lpw_brk1c", 8'h1C, 0, 0);
    frame_check("par_err", 8'h1C, 1, 0);
    frame_check("pend_f0", 8'hF0, 0, 0);
    frame_check("pend_bad", 8'h55, 1, 0);
    frame_check("stop_err", 8'h42, 0, 1);
    frame_check("pend_brk42", 8'h42, 0, 0);
    frame_check("ext_e0", 8'hE0, 0, 0);
    frame_check("ext_1c", 8'h1C, 0, 0);

    // Partial frame: start plus four data bits, then kb_clk stays high.
    fe0 = fe_cnt;
    fv0 = fv_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (2300) @(posedge clk);
    @(negedge clk);
    check("tmo.fe", 32'(fe_cnt - fe0), 32'd1);
    check("tmo.fv", 32'(fv_cnt - fv0), 32'd0);
    check("tmo.sel", 32'(ifc.sel), 32'(m_sel));
    frame_check("tmo_next_23", 8'h23, 0, 0);

    // Reset in the middle of a frame clears the note without waiting for a clock.
    drive_bit(1'b0);
    drive_bit(1'b1);
    ifc.kb_clk = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst.sel", 32'(ifc.sel), 32'd0);
    check("midrst.note_on", 32'(ifc.note_on), 32'd0);
    check("midrst.scan", 32'(ifc.scan_code), 32'd0);
    ifc.kb_clk  = 1'b1;
    ifc.kb_data = 1'b1;
    m_sel = 0; m_brk = 0; m_ext = 0; m_scan = '0;
    repeat (4) @(posedge clk);
    reset = 1'b0;
    repeat (H) @(posedge clk);
    frame_check("post_rst_34", 8'h34, 0, 0);

    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 15));
      if (r < 9)       code = key_tab[$urandom_range(0, 7)];
      else if (r < 12) code = 8'hF0;
      else if (r < 13) code = 8'hE0;
      else             code = 8'($urandom);
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 14) == 0);
      frame_check($sformatf("rnd%0d", k), code, bp, bs);
    end

    check("never_both", 32'(both_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Clock-domain PS/2 receiver and note controller for the piano.
- Oversamples raw kb_clk/kb_data on the 2.08 MHz oscillator clock and frames 11-bit packets.
- Tracks make/break (F0) prefixes and drives the 4-bit note select consumed by the clock mux and segment decoder.
- Replaces the free-running shift-register/decoder path with a checked, glitch-free, hold-until-release note state.

Parameters:
- BIT_TIMEOUT, 2080, clk cycles with no kb_clk falling edge before a partial frame is abandoned (1 ms at 2.08 MHz).
- RELEASE_CYC, 1248000, clk cycles without a repeated make code before auto-release (0.6 s); used only with the optional feature.

Ports:
- clk  in  1  2.08 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- kb_clk  in  1  raw PS/2 clock, asynchronous.
- kb_data  in  1  raw PS/2 data, asynchronous.
- sel  out  4  note select: 0 = silence, 1..8 = A3,B3,C4,D4,E4,F4,G4,A4.
- note_on  out  1  high while sel != 0.
- scan_code  out  8  last good frame payload.
- frame_valid  out  1  one-cycle pulse per good frame.
- frame_err  out  1  one-cycle pulse per bad or timed-out frame.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; prefix flags cleared.
- Synchronisation:
  - kb_clk and kb_data each pass through a 2-flop synchroniser, plus a third flop on kb_clk for edge detection.
  - A falling edge is sync2=0 while sync3=1. Data is sampled on the cycle the edge is detected.
- Frame FSM:
  - IDLE: on a falling edge with data 0 (start bit), go to SHIFT with bit_cnt=0. A falling edge with data 1 stays in IDLE and does not flag an error.
  - SHIFT: each falling edge shifts data in LSB-first (8 data bits, then parity, then stop) and increments bit_cnt. After the 10th post-start edge (stop bit), go to CHECK.
  - CHECK (1 cycle): the frame is good if odd parity holds over data+parity and stop=1.
    - Good frame: frame_valid=1, scan_code<=payload, then DECODE.
    - Bad frame: frame_err=1, then IDLE; prefix flags unchanged.
  - DECODE (1 cycle): applies the note rules below, then IDLE.
  - Timeout: in SHIFT, the timeout counter resets on every falling edge. When it reaches BIT_TIMEOUT: frame_err=1, go to IDLE, clear bit_cnt.
- Note rules in DECODE:
  - E0: set ext_pend; no note change.
  - F0: set brk_pend; no note change.
  - Mapped key code (1C,1B,23,2B,34,33,3B,42 → 1..8) with ext_pend=0:
    - brk_pend=0 (make): sel<=mapped value. Last pressed wins; a repeat of the same key keeps sel.
    - brk_pend=1 (break): sel<=0 only if mapped value == sel; a break for any other key is ignored.
  - Any non-prefix code, including unmapped or extended codes, clears both flags after use. Unmapped codes leave sel unchanged.
- Output timing: sel changes exactly 1 cycle after frame_valid, on the DECODE edge. note_on equals (sel != 0), registered together with sel.
- Reset mid-frame: immediate return to IDLE, sel=0, partial data discarded.
- frame_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: NOTE_AUTO_RELEASE_EN.
- Defined:
  - A 21-bit counter loads RELEASE_CYC on every make that sets or re-asserts sel, and decrements while sel != 0.
  - At 0, sel<=0 (covers a lost F0 break). Typematic repeats keep the note alive.
- Undefined: the counter is absent; a note is held until a matching break or reset.

Decomposition:
- Package note_pkg:
  - Enum note_t (NOTE_OFF=0, NOTE_A3..NOTE_A4).
  - Scan-code localparams SC_BREAK=8'hF0 and SC_EXT=8'hE0.
  - Key-code constants and the function scan_to_note(byte) → note_t.
  - FSM state enum (IDLE, SHIFT, CHECK, DECODE).
- One natural sub-module: ps2_sync_edge, containing the synchronisers and falling-edge detector and outputting the synced data and a fall pulse.

Test Plan:
- Make A: frame 0,1C LSB-first, parity 0, stop 1 at 10 kHz → frame_valid once, scan_code=8'h1C, sel=1 one cycle later, note_on=1.
- Break of another key: hold A, then send F0, 1B → sel stays 1. Then send F0, 1C → sel=0, note_on=0.
- Last pressed wins: make 1C then make 42 → sel=8. Then F0, 1C → sel stays 8.
- Parity error: send 1C with parity bit 1 → frame_err pulse, no frame_valid, sel unchanged. A following good F0 plus a bad frame leaves brk_pend set.
- Timeout and reset: stop kb_clk after 4 bits for more than 2080 cycles → frame_err, FSM back in IDLE, next good 23 gives sel=3. Assert reset mid-frame → sel=0 asynchronously.
- With NOTE_AUTO_RELEASE_EN and RELEASE_CYC=1000: make 2B, no break → sel=4 for 1000 cycles, then 0. A repeat make at cycle 900 extends the note to 1900.
